// File: rtl/ysyx_23060201_ifu_stream_pkg.sv
// Shared constants and types for the streaming instruction fetch unit.
package ysyx_23060201_ifu_stream_pkg;

  // Memory base: first fetch address out of reset.
  localparam logic [31:0] MBASE = 32'h8000_0000;

  // RUN issues fetches; DRAIN waits for responses of a flushed stream.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060201_ifu_fifo.sv
// Synchronous FIFO with registered head; flush wins over push and pop.
module ysyx_23060201_ifu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic [WIDTH-1:0]             head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer/count update; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_pop   = pop & ~flush & (cnt_q != '0);
    do_push  = push & ~flush & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ysyx_23060201_ifu_stream.sv
// Pipelined instruction fetch: credit-limited requests, in-order responses
// buffered in a FIFO, redirect flush with drain of stale responses.
module ysyx_23060201_ifu_stream
  import ysyx_23060201_ifu_stream_pkg::*;
#(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter logic [31:0] RESET_PC        = MBASE,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  out_err
);
  localparam int             CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int             EW      = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam logic [CW:0]    DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]  MAXO_C  = CW'(MAX_OUTSTANDING);

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
  logic [CW-1:0]         outst_q, outst_d, drop_q, drop_d, fifo_count;
  logic [CW:0]           inflight;
  logic                  fifo_full, fifo_empty, push, pop, req_fire;
  logic [EW-1:0]         fifo_head;

  // Handshake decode: credits cover both in-flight requests and buffered words,
  // so every response is guaranteed a FIFO slot.
  always_comb begin
    redir_pc  = redirect_pc & ~ADDR_WIDTH'(3);
    inflight  = {1'b0, outst_q} + {1'b0, fifo_count};
    req_valid = ~rst & (state_q == ST_RUN) & ~redirect_valid &
                (outst_q < MAXO_C) & (inflight < DEPTH_C);
    req_addr  = fetch_pc_q;
    req_fire  = req_valid & req_ready;
    push      = (state_q == ST_RUN) & rsp_valid & ~redirect_valid;
    out_valid = ~rst & ~fifo_empty & ~redirect_valid;
    pop       = out_valid & out_ready;
    out_pc    = out_valid ? fifo_head[EW-1 -: ADDR_WIDTH] : '0;
    out_inst  = out_valid ? fifo_head[DATA_WIDTH:1] : '0;
    out_err   = out_valid & fifo_head[0];
  end

  // Next-state: pc tracking, outstanding/drop counters and RUN/DRAIN transitions.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(rsp_valid);
    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    if (push)     rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(4);
    if (redirect_valid) begin
      // Everything still in flight belongs to the old stream; a response
      // landing this cycle is already accounted for.
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
      drop_d     = outst_q - CW'(rsp_valid);
      state_d    = (drop_d != '0) ? ST_DRAIN : ST_RUN;
    end else if (state_q == ST_DRAIN && rsp_valid) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) state_d = ST_RUN;
    end
  end

  // State registers, asynchronously reset to the boot fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= ADDR_WIDTH'(RESET_PC);
      rsp_pc_q   <= ADDR_WIDTH'(RESET_PC);
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  ysyx_23060201_ifu_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rsp_pc_q, rsp_data, rsp_err}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Invariants: no response without a request, no FIFO overflow, DRAIN has work.
  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> (outst_q != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> (!fifo_full || pop));
  a_drain_nonzero: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_DRAIN) |-> (drop_q != '0));

endmodule
